// File: rtl/rle_encoder.sv
// -----------------------------------------------------------------------------
// rle_encoder
//   Host-side run-length compressor. Raw N-bit words are scanned LSB first,
//   one bit per clock. The encoder emits 8-bit run codes:
//     code[7]              = value of the bits in the run
//     code[$clog2(N):0]    = run length, 1..N
//     all other code bits  = 0
//   Runs carry across word boundaries within a block. A run longer than N
//   is split into codes of length N plus the remainder. The last code of a
//   block (the block ends on a word flagged word_last) has code_eob set.
//
// Ports
//   clk         in   1  clock, rising edge
//   reset       in   1  synchronous, active-low reset
//   word_in     in   N  raw data word, scanned LSB first
//   word_valid  in   1  word_in / word_last valid
//   word_last   in   1  word_in is the final word of the block
//   word_ready  out  1  encoder accepts a word this cycle
//   code_out    out  8  run code (registered)
//   code_valid  out  1  code_out valid, held stable until accepted
//   code_ready  in   1  consumer accepts the code this cycle
//   code_eob    out  1  code_out is the final code of the block
// -----------------------------------------------------------------------------
module rle_encoder #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] word_in,
   input  logic         word_valid,
   input  logic         word_last,
   output logic         word_ready,
   output logic [7:0]   code_out,
   output logic         code_valid,
   input  logic         code_ready,
   output logic         code_eob
);

   localparam int IDX_W = $clog2(N);
   localparam int LEN_W = IDX_W + 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(N);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_EMIT  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   logic [1:0]       r_state;
   logic [N-1:0]     r_shreg;
   logic [IDX_W-1:0] r_bit_idx;
   logic             r_run_bit;
   logic [LEN_W-1:0] r_run_len;
   logic             r_last_f;
   logic [7:0]       r_code_out;
   logic             r_code_valid;
   logic             r_code_eob;

   logic             w_bit;
   logic             w_start;
   logic             w_extend;
   logic             w_consume;
   logic             w_new_bit;
   logic [LEN_W-1:0] w_new_len;
   logic             w_last_bit;
   logic [7:0]       w_code_cur;
   logic [7:0]       w_code_new;

   // Bit under examination and the run decision for it.
   assign w_bit      = r_shreg[r_bit_idx];
   assign w_start    = (r_run_len == '0);
   assign w_extend   = !w_start && (w_bit == r_run_bit) && (r_run_len < LEN_MAX);
   assign w_consume  = w_start || w_extend;
   assign w_new_bit  = w_start ? w_bit : r_run_bit;
   assign w_new_len  = w_start ? LEN_W'(1) : (r_run_len + LEN_W'(1));
   assign w_last_bit = (r_bit_idx == IDX_LAST);

   // Code for the run as it stands (bit change / cap) and for the run
   // including the bit being consumed (end of block).
   assign w_code_cur = {r_run_bit, 7'(r_run_len)};
   assign w_code_new = {w_new_bit, 7'(w_new_len)};

   assign word_ready = reset && (r_state == ST_IDLE);
   assign code_out   = r_code_out;
   assign code_valid = r_code_valid;
   assign code_eob   = r_code_eob;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_shreg      <= '0;
         r_bit_idx    <= '0;
         r_run_bit    <= 1'b0;
         r_run_len    <= '0;
         r_last_f     <= 1'b0;
         r_code_out   <= 8'h00;
         r_code_valid <= 1'b0;
         r_code_eob   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // An open run from the previous word is deliberately kept.
               if (word_valid) begin
                  r_shreg   <= word_in;
                  r_last_f  <= word_last;
                  r_bit_idx <= '0;
                  r_state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_consume) begin
                  r_run_bit <= w_new_bit;
                  r_run_len <= w_new_len;
                  if (w_last_bit) begin
                     if (r_last_f) begin
                        r_code_out   <= w_code_new;
                        r_code_valid <= 1'b1;
                        r_code_eob   <= 1'b1;
                        r_state      <= ST_FLUSH;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                  end
               end else begin
                  // Run ended by a bit change or by the length cap; the
                  // current bit stays put and is re-examined after EMIT.
                  r_code_out   <= w_code_cur;
                  r_code_valid <= 1'b1;
                  r_code_eob   <= 1'b0;
                  r_state      <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (code_ready) begin
                  r_run_len    <= '0;
                  r_code_valid <= 1'b0;
                  r_state      <= ST_SCAN;
               end
            end
            ST_FLUSH: begin
               if (code_ready) begin
                  r_run_len    <= '0;
                  r_bit_idx    <= '0;
                  r_code_valid <= 1'b0;
                  r_code_eob   <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rle_encoder.sv
module tb_rle_encoder;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] word_in;
   logic         word_valid;
   logic         word_last;
   logic         word_ready;
   logic [7:0]   code_out;
   logic         code_valid;
   logic         code_ready;
   logic         code_eob;

   int checks = 0;
   int errors = 0;

   logic [31:0] words_q[$];
   logic [8:0]  got_q[$];   // {eob, code}
   logic [8:0]  exp_q[$];

   typedef struct {
      string       name;
      logic [31:0] w0;
      logic [31:0] w1;
      int          nw;
      int          ncodes;
      logic [8:0]  c0;
      logic [8:0]  c1;
      logic [8:0]  clast;
      int          stall;
   } vec_t;

   vec_t vecs[5];

   rle_encoder #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_last  (word_last),
      .word_ready (word_ready),
      .code_out   (code_out),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code_eob   (code_eob)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the block's bits as one stream, cut a code whenever
   // the bit value changes or the run reaches N, final run closes with eob.
   task automatic model();
      int   len;
      logic rb;
      logic b;
      len = 0;
      rb  = 1'b0;
      exp_q.delete();
      foreach (words_q[w]) begin
         for (int i = 0; i < N; i++) begin
            b = words_q[w][i];
            if (len == 0) begin
               rb  = b;
               len = 1;
            end else if (b == rb && len < N) begin
               len++;
            end else begin
               exp_q.push_back({1'b0, rb, 7'(len)});
               rb  = b;
               len = 1;
            end
         end
      end
      exp_q.push_back({1'b1, rb, 7'(len)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Feeds words_q as one block and collects codes into got_q until eob.
   task automatic run_block(input int ready_pct, input int stall_first, input logic [7:0] stall_code);
      int idx;
      int cyc;
      int stalled;
      bit done;
      bit first;
      idx = 0; cyc = 0; stalled = 0; done = 0; first = 1;
      got_q.delete();
      while (!done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (idx < words_q.size() && $urandom_range(0, 3) != 0) begin
            word_in    = words_q[idx];
            word_last  = (idx == words_q.size() - 1);
            word_valid = 1'b1;
            if (word_ready) idx++;
         end else begin
            word_valid = 1'b0;
         end
         if (code_valid && first && stalled < stall_first) begin
            code_ready = 1'b0;
            stalled++;
            check("stall_code_out", 32'(code_out), 32'(stall_code));
            check("stall_code_valid", 32'(code_valid), 32'd1);
            check("stall_word_ready", 32'(word_ready), 32'd0);
         end else begin
            code_ready = ($urandom_range(0, 99) < ready_pct);
         end
         if (code_valid && code_ready) begin
            got_q.push_back({code_eob, code_out});
            first = 0;
            if (code_eob) done = 1;
         end
      end
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      code_ready = 1'b0;
      check("block_done", 32'(done), 32'd1);
      if (!done) begin
         do_reset();
      end else begin
         check("ready_after_eob", 32'(word_ready), 32'd1);
      end
   endtask

   initial begin
      reset      = 1'b0;
      word_in    = '0;
      word_valid = 1'b0;
      word_last  = 1'b0;
      code_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_word_ready", 32'(word_ready), 32'd0);
      check("rst_code_valid", 32'(code_valid), 32'd0);
      check("rst_code_eob", 32'(code_eob), 32'd0);
      check("rst_code_out", 32'(code_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst_word_ready", 32'(word_ready), 32'd1);

      // Directed table
      vecs[0] = '{"half_ones",  32'h0000FFFF, 32'h0,        1, 2,  9'h090, 9'h110, 9'h110, 0};
      vecs[1] = '{"cap32",      32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2,  9'h0A0, 9'h1A0, 9'h1A0, 0};
      vecs[2] = '{"alternate",  32'hAAAAAAAA, 32'h0,        1, 32, 9'h001, 9'h081, 9'h181, 0};
      vecs[3] = '{"span_words", 32'h80000000, 32'h00000001, 2, 3,  9'h01F, 9'h082, 9'h11F, 0};
      vecs[4] = '{"backpress",  32'h0000FFFF, 32'h0,        1, 2,  9'h090, 9'h110, 9'h110, 5};

      for (int v = 0; v < 5; v++) begin
         words_q.delete();
         words_q.push_back(vecs[v].w0);
         if (vecs[v].nw == 2) words_q.push_back(vecs[v].w1);
         run_block(vecs[v].stall != 0 ? 100 : 75, vecs[v].stall, 8'h90);
         check({vecs[v].name, "_count"}, 32'(got_q.size()), 32'(vecs[v].ncodes));
         while (got_q.size() < 2) got_q.push_back(9'h000);
         check({vecs[v].name, "_first"}, 32'(got_q[0]), 32'(vecs[v].c0));
         check({vecs[v].name, "_second"}, 32'(got_q[1]), 32'(vecs[v].c1));
         check({vecs[v].name, "_last"}, 32'(got_q[got_q.size()-1]), 32'(vecs[v].clast));
         $display("vector %s: %0d codes, last 0x%0h", vecs[v].name, got_q.size(), got_q[got_q.size()-1]);
      end

      // Reset mid-SCAN, then a clean block
      @(negedge clk);
      word_in    = 32'hAAAAAAAA;
      word_last  = 1'b1;
      word_valid = 1'b1;
      code_ready = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset      = 1'b1;
      code_ready = 1'b0;
      #1;
      check("midrst_code_valid", 32'(code_valid), 32'd0);
      check("midrst_code_eob", 32'(code_eob), 32'd0);
      check("midrst_code_out", 32'(code_out), 32'd0);
      check("midrst_word_ready", 32'(word_ready), 32'd1);
      words_q.delete();
      words_q.push_back(32'h0000FFFF);
      run_block(100, 0, 8'h00);
      check("midrst_rerun_count", 32'(got_q.size()), 32'd2);
      while (got_q.size() < 2) got_q.push_back(9'h000);
      check("midrst_rerun_first", 32'(got_q[0]), 32'h090);
      check("midrst_rerun_second", 32'(got_q[1]), 32'h110);
      $display("reset mid-scan: rerun gave %0d codes", got_q.size());

      // Randomized blocks against the reference model
      for (int blk = 0; blk < 100; blk++) begin
         int nw;
         int mism;
         nw = $urandom_range(1, 3);
         words_q.delete();
         for (int i = 0; i < nw; i++) begin
            case ($urandom_range(0, 3))
               0: words_q.push_back($urandom);
               1: words_q.push_back($urandom_range(0, 1) != 0 ? 32'hFFFFFFFF : 32'h0);
               2: words_q.push_back($urandom & $urandom & $urandom);
               default: words_q.push_back(32'hFFFFFFFF << $urandom_range(0, 31));
            endcase
         end
         model();
         run_block(70, 0, 8'h00);
         check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
         mism = 0;
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) mism++;
            check("rand_code", 32'(got_q[i]), 32'(exp_q[i]));
         end
         $display("random block %0d: %0d words, %0d codes, %0d mismatched", blk, nw, got_q.size(), mism);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
